// File: rtl/keypad_pkg.sv
// Shared types and elaboration-time helpers for the keypad scan controller.
package keypad_pkg;

    // Scan sequencer states: settle after a column change, then walk the rows.
    typedef enum logic {
        DRIVE  = 1'b0,
        SAMPLE = 1'b1
    } scan_state_t;

    // Cycles to wait after a column change; never fewer than the 2-flop
    // synchronizer plus one cycle of margin.
    function automatic int settle_cycles(input int freq_mhz, input int time_ns);
        int raw;
        raw = (time_ns * freq_mhz) / 1000;
        return (raw < 3) ? 3 : raw;
    endfunction

    // Width of an index into n items, kept at least 1 bit wide.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a key code row*COLS + col.
    function automatic int code_width(input int rows, input int cols);
        return idx_width(rows * cols);
    endfunction

    // Width of a per-key debounce counter that must hold the value 'scans'.
    function automatic int cnt_width(input int scans);
        return $clog2(scans + 1);
    endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// Small synchronous event FIFO; a push into a full FIFO with no pop is
// discarded and reported with a one-cycle drop pulse.
module keypad_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             drop_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             drop_q;
    logic             pop_en, push_en;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pop_en  = pop_i & ~empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_en = push_i & (~full_o | pop_en);
    assign data_o  = mem_q[rd_ptr_q];
    assign drop_o  = drop_q;

    // Storage write port.
    // NOTE: the data array has no reset; the count decides what is valid, so
    // clearing the entries would only add reset fan-out.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers, occupancy and the drop pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            drop_q <= push_i & ~push_en;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: drives one column at a time, debounces every key
// through a shared time-multiplexed sampling path and queues press events.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int CLK_FREQ_MHZ   = 100,
    parameter int SETTLE_TIME_NS = 50,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [ROWS-1:0]                     row_i,
    output logic [COLS-1:0]                     col_o,
    output logic [code_width(ROWS, COLS)-1:0]   key_code_o,
    output logic                                key_valid_o,
    input  logic                                key_ready_i,
    output logic                                overflow_o
);

    localparam int KEYS   = ROWS * COLS;
    localparam int CODE_W = code_width(ROWS, COLS);
    localparam int CNT_W  = cnt_width(DEBOUNCE_SCANS);
    localparam int ROW_W  = idx_width(ROWS);
    localparam int COL_W  = idx_width(COLS);
    localparam int SETTLE = settle_cycles(CLK_FREQ_MHZ, SETTLE_TIME_NS);
    localparam int SET_W  = idx_width(SETTLE);

    // Scan sequencer
    scan_state_t      state_q, state_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [ROW_W-1:0] r_q, r_d;
    logic [COL_W-1:0] c_q, c_d;
    logic             active_q;
    logic [COLS-1:0]  col_q;

    // Row synchronizer
    logic [ROWS-1:0]  row_meta_q, row_sync_q;

    // Per-key debounce state and the event register feeding the FIFO
    logic [KEYS-1:0]   stable_q;
    logic [CNT_W-1:0]  cnt_q [KEYS];
    logic              evt_q;
    logic [CODE_W-1:0] evt_code_q;

    // Shared sampling path
    logic              sampling;
    logic [CODE_W-1:0] key_idx;
    logic              pressed;
    logic [CNT_W-1:0]  cnt_inc;

    logic fifo_empty;
    logic unused_fifo_full;

    assign col_o       = col_q;
    assign key_valid_o = ~fifo_empty;

    // Two-flop synchronizer for the asynchronous row lines; idle level is high.
    // NOTE: every clocked block uses non-blocking assignments so all flops
    // update together and simulation order cannot change the result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_meta_q <= '1;
            row_sync_q <= '1;
        end else begin
            row_meta_q <= row_i;
            row_sync_q <= row_meta_q;
        end
    end

    // Sequencer registers; the first edge after reset only turns on column 0,
    // so its settle window is as long as every other column's.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= DRIVE;
            settle_q <= '0;
            r_q      <= '0;
            c_q      <= '0;
            active_q <= 1'b0;
            col_q    <= '1;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            r_q      <= r_d;
            c_q      <= c_d;
            active_q <= 1'b1;
            col_q    <= ~(COLS'(1) << c_d);
        end
    end

    // Next-state logic: settle on a column, then walk its rows, then advance.
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        r_d      = r_q;
        c_d      = c_q;
        if (active_q) begin
            unique case (state_q)
                DRIVE: begin
                    if (settle_q == SET_W'(SETTLE - 1)) begin
                        state_d  = SAMPLE;
                        settle_d = '0;
                        r_d      = '0;
                    end else begin
                        settle_d = settle_q + SET_W'(1);
                    end
                end
                SAMPLE: begin
                    if (r_q == ROW_W'(ROWS - 1)) begin
                        state_d = DRIVE;
                        r_d     = '0;
                        c_d     = (c_q == COL_W'(COLS - 1)) ? '0 : c_q + COL_W'(1);
                    end else begin
                        r_d = r_q + ROW_W'(1);
                    end
                end
                default: state_d = DRIVE;
            endcase
        end
    end

    // Select the key under test this cycle and its candidate counter value.
    always_comb begin
        sampling = active_q && (state_q == SAMPLE);
        key_idx  = CODE_W'(int'(r_q) * COLS + int'(c_q));
        pressed  = ~row_sync_q[r_q];
        cnt_inc  = cnt_q[key_idx] + CNT_W'(1);
    end

    // Debounce update for the selected key; a debounced press raises an event
    // that is pushed into the FIFO on the following cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stable_q   <= '0;
            for (int k = 0; k < KEYS; k++) begin
                cnt_q[k] <= '0;
            end
            evt_q      <= 1'b0;
            evt_code_q <= '0;
        end else begin
            evt_q <= 1'b0;
            if (sampling) begin
                evt_code_q <= key_idx;
                if (pressed == stable_q[key_idx]) begin
                    cnt_q[key_idx] <= '0;
                end else if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
                    stable_q[key_idx] <= pressed;
                    cnt_q[key_idx]    <= '0;
                    evt_q             <= pressed;
                end else begin
                    cnt_q[key_idx] <= cnt_inc;
                end
            end
        end
    end

    // Event queue toward the consumer; the drop pulse is the overflow flag and
    // the full flag is left for other users of the FIFO.
    keypad_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CODE_W)
    ) u_evt_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (evt_q),
        .data_i  (evt_code_q),
        .pop_i   (key_ready_i),
        .data_o  (key_code_o),
        .full_o  (unused_fifo_full),
        .empty_o (fifo_empty),
        .drop_o  (overflow_o)
    );

endmodule
